// File: rtl/latch_bank_arbiter.sv
// ----------------------------------------------------------------------------
// latch_bank_arbiter
//
// Purpose:
//   Round-robin arbiter and write sequencer for a shared bank of DEPTH
//   transparent latches (WIDTH bits each) that all sit on one common data bus.
//   One requester is granted at a time. Each write runs through a fixed
//   sequence: the data bus settles (SETUP), then the selected enable is held
//   high for OPEN_CYCLES cycles (OPEN), then it drops while the data is still
//   held (HOLD). lat_en and lat_d are driven straight from flops, so the
//   enables are glitch-free. lat_d never changes while any enable is high.
//   The latches themselves live outside this block.
//
// Parameters:
//   NREQ        number of requesters (2..8)
//   DEPTH       number of latches in the bank
//   WIDTH       latch data width
//   OPEN_CYCLES cycles the selected enable stays high (>= 1)
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   req       per-requester write request (level, held until done/err)
//   req_addr  packed addresses, requester i at [i*AW +: AW]
//   req_data  packed data, requester i at [i*WIDTH +: WIDTH]
//   done      one-cycle one-hot completion pulse
//   err       one-cycle one-hot address-error pulse (address >= DEPTH)
//   lat_en    registered one-hot latch enable
//   lat_d     registered latch data bus
//   busy      high whenever a write sequence is in progress
//
// Build option:
//   LATCH_ARB_FIXED_PRIO_EN  when defined, fixed priority (lowest index
//                            wins) replaces round-robin and the rotating
//                            pointer is removed.
// ----------------------------------------------------------------------------
module latch_bank_arbiter #(
    parameter int NREQ        = 4,
    parameter int DEPTH       = 8,
    parameter int WIDTH       = 8,
    parameter int OPEN_CYCLES = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NREQ-1:0]                   req,
    input  logic [NREQ*$clog2(DEPTH)-1:0]     req_addr,
    input  logic [NREQ*WIDTH-1:0]             req_data,
    output logic [NREQ-1:0]                   done,
    output logic [NREQ-1:0]                   err,
    output logic [DEPTH-1:0]                  lat_en,
    output logic [WIDTH-1:0]                  lat_d,
    output logic                              busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(NREQ);
    localparam int CW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        OPEN,
        HOLD
    } state_t;

    state_t          state;
    logic [PW-1:0]   cap_win;
    logic [AW-1:0]   cap_addr;
    logic [CW-1:0]   open_cnt;

    logic [PW-1:0]   win;
    logic            any_req;
    logic [AW-1:0]   sel_addr;
    logic [WIDTH-1:0] sel_data;
    logic            addr_bad;

`ifndef LATCH_ARB_FIXED_PRIO_EN
    logic [PW-1:0]   rr_ptr;

    // Pointer after serving w: the requester just above it, wrapping.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] w);
        if (int'(w) == NREQ - 1) begin
            return '0;
        end
        return w + PW'(1);
    endfunction
`endif

    // Winner search. Round-robin starts at rr_ptr and wraps; fixed priority
    // starts at index 0. The first set request bit encountered wins.
    always_comb begin : pick_winner
        int idx;
        idx     = 0;
        win     = '0;
        any_req = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef LATCH_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (int'(rr_ptr) + k) % NREQ;
`endif
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                win     = PW'(idx);
            end
        end
    end

    assign sel_addr = req_addr[int'(win)*AW +: AW];
    assign sel_data = req_data[int'(win)*WIDTH +: WIDTH];
    // Only meaningful when DEPTH is not a power of two.
    assign addr_bad = (int'(sel_addr) >= DEPTH);

    assign busy = (state != IDLE);

    // Sequencer. lat_d is loaded only on the IDLE->SETUP transition and
    // lat_en only rises on SETUP->OPEN, so the data bus is always settled a
    // full cycle before any enable opens and stays put until HOLD is over.
    // A bad address leaves lat_d untouched and just pulses err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cap_win  <= '0;
            cap_addr <= '0;
            open_cnt <= '0;
            lat_en   <= '0;
            lat_d    <= '0;
            done     <= '0;
            err      <= '0;
`ifndef LATCH_ARB_FIXED_PRIO_EN
            rr_ptr   <= '0;
`endif
        end else begin
            done <= '0;
            err  <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        cap_win  <= win;
                        cap_addr <= sel_addr;
                        if (addr_bad) begin
                            err    <= NREQ'(1) << win;
`ifndef LATCH_ARB_FIXED_PRIO_EN
                            rr_ptr <= next_ptr(win);
`endif
                        end else begin
                            lat_d <= sel_data;
                            state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    lat_en   <= DEPTH'(1) << cap_addr;
                    open_cnt <= CW'(OPEN_CYCLES - 1);
                    state    <= OPEN;
                end
                OPEN: begin
                    if (open_cnt == '0) begin
                        lat_en <= '0;
                        done   <= NREQ'(1) << cap_win;
`ifndef LATCH_ARB_FIXED_PRIO_EN
                        rr_ptr <= next_ptr(cap_win);
`endif
                        state  <= HOLD;
                    end else begin
                        open_cnt <= open_cnt - CW'(1);
                    end
                end
                HOLD: begin
                    state <= IDLE;
                end
                default: begin
                    lat_en <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// ----------------------------------------------------------------------------
// tb_latch_bank_arbiter
//
// Purpose:
//   Directed self-checking bench for latch_bank_arbiter. Instance dut uses
//   the default DEPTH=8; instance dut_b uses DEPTH=6 so that out-of-range
//   addresses exist. Both share clock and reset.
//
// Ports: none (top-level bench).
//
// Build option:
//   LATCH_ARB_FIXED_PRIO_EN  changes the expected contention order to
//                            requester 0 every time.
// ----------------------------------------------------------------------------
module tb_latch_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int OC    = 2;
    localparam int AW    = 3;

    logic                  clk;
    logic                  rst_n;

    logic [NREQ-1:0]       req;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       done;
    logic [NREQ-1:0]       err;
    logic [7:0]            lat_en;
    logic [WIDTH-1:0]      lat_d;
    logic                  busy;

    logic [NREQ-1:0]       b_req;
    logic [NREQ*AW-1:0]    b_req_addr;
    logic [NREQ*WIDTH-1:0] b_req_data;
    logic [NREQ-1:0]       b_done;
    logic [NREQ-1:0]       b_err;
    logic [5:0]            b_lat_en;
    logic [WIDTH-1:0]      b_lat_d;
    logic                  b_busy;

    int checks   = 0;
    int failures = 0;

    latch_bank_arbiter #(
        .NREQ(NREQ), .DEPTH(8), .WIDTH(WIDTH), .OPEN_CYCLES(OC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
        .req_data(req_data), .done(done), .err(err), .lat_en(lat_en),
        .lat_d(lat_d), .busy(busy)
    );

    latch_bank_arbiter #(
        .NREQ(NREQ), .DEPTH(6), .WIDTH(WIDTH), .OPEN_CYCLES(OC)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .req(b_req), .req_addr(b_req_addr),
        .req_data(b_req_data), .done(b_done), .err(b_err), .lat_en(b_lat_en),
        .lat_d(b_lat_d), .busy(b_busy)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Counts one comparison and reports it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives request vector and one requester's address/data on dut.
    task automatic applyStimulus(input logic [NREQ-1:0] r, input int i,
                                 input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        req_addr[i*AW +: AW]       = a;
        req_data[i*WIDTH +: WIDTH] = d;
        req                        = r;
    endtask

    // Advance one cycle; return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        req   = '0;
        b_req = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Invariants on both instances, checked every cycle out of reset.
    logic [WIDTH-1:0] prev_lat_d;
    logic [WIDTH-1:0] prev_b_lat_d;
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("onehot0_lat_en", 32'($onehot0(lat_en)), 32'd1);
            checkOutput("onehot0_b_lat_en", 32'($onehot0(b_lat_en)), 32'd1);
            if (lat_en != '0) checkOutput("lat_d_stable", 32'(lat_d), 32'(prev_lat_d));
            if (b_lat_en != '0) checkOutput("b_lat_d_stable", 32'(b_lat_d), 32'(prev_b_lat_d));
        end
        prev_lat_d   = lat_d;
        prev_b_lat_d = b_lat_d;
    end

    initial begin
        logic [NREQ-1:0] exp_done;
        int              cnt;

        rst_n      = 1'b0;
        req        = '0;
        req_addr   = '0;
        req_data   = '0;
        b_req      = '0;
        b_req_addr = '0;
        b_req_data = '0;
        #23;

        // ---------------- reset state ----------------
        checkOutput("rst_lat_en", 32'(lat_en), 32'h0);
        checkOutput("rst_lat_d", 32'(lat_d), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---------------- single write ----------------
        applyStimulus(4'b0001, 0, 3'd3, 8'hA5);
        tick();                                        // cycle 1: SETUP
        checkOutput("w1_c1_lat_d", 32'(lat_d), 32'hA5);
        checkOutput("w1_c1_lat_en", 32'(lat_en), 32'h00);
        checkOutput("w1_c1_busy", 32'(busy), 32'h1);
        tick();                                        // cycle 2: OPEN
        checkOutput("w1_c2_lat_en", 32'(lat_en), 32'h08);
        tick();                                        // cycle 3: OPEN
        checkOutput("w1_c3_lat_en", 32'(lat_en), 32'h08);
        checkOutput("w1_c3_done", 32'(done), 32'h0);
        tick();                                        // cycle 4: HOLD
        checkOutput("w1_c4_lat_en", 32'(lat_en), 32'h00);
        checkOutput("w1_c4_done", 32'(done), 32'h1);
        checkOutput("w1_c4_lat_d", 32'(lat_d), 32'hA5);
        req = '0;
        tick();                                        // cycle 5: IDLE
        checkOutput("w1_c5_done", 32'(done), 32'h0);
        checkOutput("w1_c5_busy", 32'(busy), 32'h0);

        // ---------------- contention ----------------
        resetDut();
        for (int i = 0; i < NREQ; i++) applyStimulus(4'b1111, i, 3'(i + 1), 8'(8'h10 + i));
        for (int n = 0; n < 5; n++) begin
            cnt = 0;
            do begin
                tick();
                cnt++;
            end while (done == '0 && cnt < 20);
`ifdef LATCH_ARB_FIXED_PRIO_EN
            exp_done = 4'b0001;
`else
            exp_done = 4'b0001 << (n % NREQ);
`endif
            checkOutput($sformatf("cont_done_%0d", n), 32'(done), 32'(exp_done));
            checkOutput($sformatf("cont_gap_%0d", n), 32'(cnt), (n == 0) ? 32'd4 : 32'd5);
`ifdef LATCH_ARB_FIXED_PRIO_EN
            checkOutput($sformatf("cont_lat_d_%0d", n), 32'(lat_d), 32'h10);
`else
            checkOutput($sformatf("cont_lat_d_%0d", n), 32'(lat_d), 32'(8'h10 + (n % NREQ)));
`endif
        end
        req = '0;
        tick();
        tick();

        // ---------------- mid-transaction input change ----------------
        resetDut();
        applyStimulus(4'b0010, 1, 3'd5, 8'h3C);
        tick();                                        // cycle 1
        checkOutput("mid_c1_lat_d", 32'(lat_d), 32'h3C);
        tick();                                        // cycle 2: OPEN
        checkOutput("mid_c2_lat_en", 32'(lat_en), 32'h20);
        applyStimulus(4'b0000, 1, 3'd5, 8'hFF);
        tick();                                        // cycle 3
        checkOutput("mid_c3_lat_d", 32'(lat_d), 32'h3C);
        checkOutput("mid_c3_lat_en", 32'(lat_en), 32'h20);
        tick();                                        // cycle 4: HOLD
        checkOutput("mid_c4_done", 32'(done), 32'h2);
        checkOutput("mid_c4_lat_d", 32'(lat_d), 32'h3C);
        tick();
        checkOutput("mid_c5_busy", 32'(busy), 32'h0);
        checkOutput("mid_c5_lat_d", 32'(lat_d), 32'h3C);

        // ---------------- reset mid-OPEN ----------------
        resetDut();
        applyStimulus(4'b0100, 2, 3'd6, 8'h77);
        tick();
        tick();                                        // cycle 2: OPEN
        checkOutput("rmo_lat_en_open", 32'(lat_en), 32'h40);
        rst_n = 1'b0;
        #1;
        checkOutput("rmo_async_lat_en", 32'(lat_en), 32'h00);
        checkOutput("rmo_async_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rmo_no_done", 32'(done), 32'h0);
        end
        applyStimulus(4'b0101, 0, 3'd1, 8'h11);
        rst_n = 1'b1;
        tick();                                        // cycle 1 after release
        checkOutput("rmo_rel_lat_d", 32'(lat_d), 32'h11);
        tick();
        checkOutput("rmo_rel_lat_en", 32'(lat_en), 32'h02);
        tick();
        tick();                                        // HOLD
        checkOutput("rmo_rel_done", 32'(done), 32'h1);
        req = '0;
        tick();
        tick();
        tick();
        tick();

        // ---------------- bad address (DEPTH=6 instance) ----------------
        resetDut();
        b_req_addr[2*AW +: AW]       = 3'd7;
        b_req_data[2*WIDTH +: WIDTH] = 8'hEE;
        b_req_addr[3*AW +: AW]       = 3'd2;
        b_req_data[3*WIDTH +: WIDTH] = 8'h5A;
        b_req = 4'b1100;
        tick();                                        // cycle 1
        checkOutput("bad_err", 32'(b_err), 32'h4);
        checkOutput("bad_done", 32'(b_done), 32'h0);
        checkOutput("bad_lat_en", 32'(b_lat_en), 32'h0);
        checkOutput("bad_busy", 32'(b_busy), 32'h0);
        checkOutput("bad_lat_d", 32'(b_lat_d), 32'h0);
        b_req = 4'b1000;
        tick();                                        // cycle 2: SETUP for req 3
        checkOutput("bad_err_clear", 32'(b_err), 32'h0);
        checkOutput("bad_next_lat_d", 32'(b_lat_d), 32'h5A);
        tick();                                        // cycle 3: OPEN
        checkOutput("bad_next_lat_en", 32'(b_lat_en), 32'h04);
        tick();
        tick();                                        // cycle 5: HOLD
        checkOutput("bad_next_done", 32'(b_done), 32'h8);
        b_req = '0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
